// File: rtl/unshift_matrix.sv
// Reassembles a SIZE x SIZE matrix from a diagonally skewed beat stream
// (2*SIZE-1 beats) and presents it under a valid/ready handshake.
module unshift_matrix #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SIZE  = 3
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE*WIDTH-1:0] in_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      Mout [SIZE-1:0][SIZE-1:0],
  output logic                  busy
);

  localparam int unsigned NumBeats = 2 * SIZE - 1;
  localparam int unsigned CntW     = $clog2(NumBeats);
  localparam logic [CntW-1:0] LastBeat = CntW'(NumBeats - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StFull} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mout_q [SIZE-1:0][SIZE-1:0];

  logic accept;
  logic wr_en;

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q == StFull);
  assign busy      = (state_q == StCollect);
  assign accept    = in_valid && in_ready;
  // A flushed beat is dropped entirely, including its matrix writes.
  assign wr_en     = accept && !flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = StCollect;
            cnt_d   = CntW'(1);
          end
        end
        StCollect: begin
          if (accept) begin
            // Counter saturates on the last beat; FULL clears it on handoff.
            if (cnt_q == LastBeat) begin
              state_d = StFull;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StFull: begin
          if (out_ready) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lane c of beat b lands on row b-c; lanes outside the matrix never match.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int r = 0; r < int'(SIZE); r++) begin
        for (int c = 0; c < int'(SIZE); c++) begin
          mout_q[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int r = 0; r < int'(SIZE); r++) begin
        for (int c = 0; c < int'(SIZE); c++) begin
          if (cnt_q == CntW'(r + c)) begin
            mout_q[r][c] <= in_vec[c*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < int'(SIZE); r++) begin
      for (int c = 0; c < int'(SIZE); c++) begin
        Mout[r][c] = mout_q[r][c];
      end
    end
  end

  no_write_when_full: assert property (@(posedge clock) disable iff (!nreset)
    (state_q == StFull) |-> !wr_en);

endmodule
